// File: rtl/fq_ts_release_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fq_ts_release_queue                                                    |
// | Holds timestamped flits in arrival order and releases each head flit   |
// | once simulated time reaches its departure stamp.                       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fq_ts_release_queue #(
    parameter int TS_WIDTH   = 10,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [TS_WIDTH-1:0]      sim_time,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TS_WIDTH-1:0]      in_timestamp,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_WIDTH-1:0]      out_timestamp,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_WIDTH-1:0]     late_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]      PTR_ONE  = AW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TS_WIDTH-1:0]    r_ts_mem   [DEPTH];
    logic [DATA_WIDTH-1:0]  r_data_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_occ;
    logic                   r_late;
    logic [CNT_WIDTH-1:0]   r_late_cnt;

    logic                   w_push;
    logic                   w_pop;
    logic [TS_WIDTH-1:0]    w_diff;
    logic                   w_due;
    logic                   w_late;
    logic [AW:0]            w_occ_nxt;

    assign in_ready      = (r_occ != OCC_FULL);
    assign w_push        = in_valid && in_ready;
    assign w_pop         = (r_state == ST_PRESENT) && out_ready;
    assign w_occ_nxt     = r_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    // Modular difference: a stamp up to half the range in the past counts as due.
    assign w_diff        = sim_time - r_ts_mem[r_rd_ptr];
    assign w_due         = ~w_diff[TS_WIDTH-1];
    assign w_late        = w_due && (w_diff != '0);

    assign out_timestamp = r_ts_mem[r_rd_ptr];
    assign out_data      = r_data_mem[r_rd_ptr];
    assign occupancy     = r_occ;
    assign late_count    = r_late_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ts_mem[i]   <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_ts_mem[r_wr_ptr]   <= in_timestamp;
            r_data_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_occ <= w_occ_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_late     <= 1'b0;
            r_late_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Lateness is captured when the flit is first presented, not when it leaves.
            if (r_state == ST_WAIT && w_due) begin
                r_late <= w_late;
            end
            if (w_pop && r_late && (r_late_cnt != '1)) begin
                r_late_cnt <= r_late_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_due) begin
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                out_valid = 1'b1;
                if (w_pop) begin
                    w_state_nxt = (w_occ_nxt == '0) ? ST_IDLE : ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fq_ts_release_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fq_ts_release_queue                                                 |
// | Directed and randomized bench with a queue-based reference model.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_fq_ts_release_queue;

    localparam int TSW = 10;
    localparam int DW  = 16;
    localparam int DEP = 4;
    localparam int CW  = 8;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [TSW-1:0] sim_time = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [TSW-1:0] in_timestamp = '0;
    logic [DW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [TSW-1:0] out_timestamp;
    logic [DW-1:0]  out_data;
    logic [2:0]     occupancy;
    logic [CW-1:0]  late_count;

    fq_ts_release_queue #(
        .TS_WIDTH(TSW), .DATA_WIDTH(DW), .DEPTH(DEP), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .sim_time(sim_time),
        .in_valid(in_valid), .in_ready(in_ready), .in_timestamp(in_timestamp),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_timestamp(out_timestamp), .out_data(out_data),
        .occupancy(occupancy), .late_count(late_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue of pending flits plus "head is on the output" flag.
    int q_ts[$];
    int q_data[$];
    bit m_pres;
    bit m_late;
    int m_lc;

    function automatic int age(int now, int ts);
        return (now - ts + 1024) % 1024;
    endfunction

    function automatic void model_reset();
        q_ts.delete();
        q_data.delete();
        m_pres = 0;
        m_late = 0;
        m_lc   = 0;
    endfunction

    function automatic void model_step();
        bit pop  = m_pres && out_ready;
        bit push = in_valid && (q_ts.size() < DEP);
        if (m_pres) begin
            if (pop) begin
                if (m_late && m_lc < 255) m_lc++;
                m_pres = 0;
            end
        end else if (q_ts.size() > 0 && age(int'(sim_time), q_ts[0]) < 512) begin
            m_pres = 1;
            m_late = age(int'(sim_time), q_ts[0]) != 0;
        end
        if (pop) begin
            void'(q_ts.pop_front());
            void'(q_data.pop_front());
        end
        if (push) begin
            q_ts.push_back(int'(in_timestamp));
            q_data.push_back(int'(in_data));
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic drain(output bit ok);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 64 && (q_ts.size() > 0 || m_pres); k++) tick();
        ok = (q_ts.size() == 0) && !m_pres;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 3'd0 ||
            late_count !== 8'd0 || out_data !== 16'd0 || out_timestamp !== 10'd0) begin
            n_bad++;
            $display("FAIL reset_init: valid=%b ready=%b occ=%0d lc=%0d data=%h ts=%0d, want 0 1 0 0 0 0",
                     out_valid, in_ready, occupancy, late_count, out_data, out_timestamp);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        sim_time = 10'd3; in_valid = 1'b1; in_timestamp = 10'd3; in_data = 16'h1234;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_setup_present: out_valid=%b, want 1", out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1 || out_data !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid_present: valid=%b occ=%0d ready=%b data=%h, want 0 0 1 0",
                     out_valid, occupancy, in_ready, out_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_due_delay();
        sim_time = 10'd5; out_ready = 1'b1;
        in_valid = 1'b1; in_timestamp = 10'd8; in_data = 16'hA5A5;
        tick();
        in_valid = 1'b0;
        for (int t = 6; t <= 8; t++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL due_early: at sim_time=%0d out_valid=%b, want 0", sim_time, out_valid);
            end
            sim_time = 10'(t);
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_timestamp !== 10'd8 || out_data !== 16'hA5A5 || late_count !== 8'd0) begin
            n_bad++;
            $display("FAIL due_release: valid=%b ts=%0d data=%h lc=%0d, want 1 8 a5a5 0",
                     out_valid, out_timestamp, out_data, late_count);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
            n_bad++;
            $display("FAIL due_pop: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int seq[6] = '{1021, 1022, 1023, 0, 1, 2};
        sim_time = 10'd1020; out_ready = 1'b1;
        in_valid = 1'b1; in_timestamp = 10'd2; in_data = 16'h0202;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sim_time = 10'(seq[k]);
            tick();
            n_cmp++;
            if (out_valid !== (k == 5)) begin
                n_bad++;
                $display("FAIL wrap_due: sim_time=%0d out_valid=%b, want %0d", sim_time, out_valid, k == 5);
            end
        end
        tick();
        sim_time = 10'd1020;
        in_valid = 1'b1; in_timestamp = 10'd1000; in_data = 16'h03E8;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_timestamp !== 10'd1000) begin
            n_bad++;
            $display("FAIL wrap_past_release: valid=%b ts=%0d, want 1 1000", out_valid, out_timestamp);
        end
        tick();
        n_cmp++;
        if (late_count !== 8'd1) begin
            n_bad++;
            $display("FAIL wrap_late_count: late_count=%0d, want 1", late_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        bit iv[5]  = '{1, 1, 0, 0, 1};
        bit orr[5] = '{1, 0, 1, 0, 1};
        int eocc[5] = '{3, 4, 3, 3, 3};
        bit ok;
        sim_time = 10'd100; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_timestamp = 10'(100 - i); in_data = 16'($urandom);
            tick();
        end
        n_cmp++;
        if (occupancy !== 3'd4 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_fill: occ=%0d ready=%b, want 4 0", occupancy, in_ready);
        end
        in_data = 16'hBEEF;
        tick();
        n_cmp++;
        if (occupancy !== 3'd4 || out_data !== 16'(q_data[0])) begin
            n_bad++;
            $display("FAIL full_fifth_ignored: occ=%0d head=%h, want 4 %h", occupancy, out_data, 16'(q_data[0]));
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = iv[k]; out_ready = orr[k]; in_data = 16'hC000 + 16'(k);
            tick();
            n_cmp++;
            if (occupancy !== 3'(eocc[k]) || occupancy !== 3'(q_ts.size())) begin
                n_bad++;
                $display("FAIL full_step%0d: occ=%0d, want %0d", k, occupancy, eocc[k]);
            end
        end
        drain(ok);
        n_cmp++;
        if (!ok || occupancy !== 3'd0 || late_count !== 8'(m_lc)) begin
            n_bad++;
            $display("FAIL full_drain: ok=%0d occ=%0d lc=%0d, want 1 0 %0d", ok, occupancy, late_count, m_lc);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0]  hold_d;
        int             lc0;
        sim_time = 10'd300; out_ready = 1'b0;
        hold_d = 16'($urandom);
        in_valid = 1'b1; in_timestamp = 10'd300; in_data = hold_d;
        tick();
        in_valid = 1'b0;
        tick();
        lc0 = m_lc;
        for (int k = 0; k < 10; k++) begin
            sim_time = sim_time + 10'd7;
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== hold_d || out_timestamp !== 10'd300) begin
                n_bad++;
                $display("FAIL bp_hold%0d: valid=%b data=%h ts=%0d, want 1 %h 300",
                         k, out_valid, out_data, out_timestamp, hold_d);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || late_count !== 8'(lc0)) begin
            n_bad++;
            $display("FAIL bp_single_pop: valid=%b occ=%0d lc=%0d, want 0 0 %0d", out_valid, occupancy, late_count, lc0);
        end
    endtask

    task automatic test_order();
        int lc0 = m_lc;
        sim_time = 10'd15; out_ready = 1'b1;
        in_valid = 1'b1; in_timestamp = 10'd20; in_data = 16'h0020;
        tick();
        in_timestamp = 10'd10; in_data = 16'h0010;
        tick();
        in_valid = 1'b0;
        for (int t = 16; t <= 20; t++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL order_hold: sim_time=%0d out_valid=%b, want 0", sim_time, out_valid);
            end
            sim_time = 10'(t);
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_timestamp !== 10'd20 || out_data !== 16'h0020) begin
            n_bad++;
            $display("FAIL order_first: valid=%b ts=%0d data=%h, want 1 20 0020", out_valid, out_timestamp, out_data);
        end
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_timestamp !== 10'd10 || out_data !== 16'h0010) begin
            n_bad++;
            $display("FAIL order_second: valid=%b ts=%0d data=%h, want 1 10 0010", out_valid, out_timestamp, out_data);
        end
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (late_count !== 8'(lc0 + 1) || occupancy !== 3'd0) begin
            n_bad++;
            $display("FAIL order_late: lc=%0d occ=%0d, want %0d 0", late_count, occupancy, lc0 + 1);
        end
    endtask

    task automatic test_random();
        sim_time = 10'd1000;
        for (int c = 0; c < 800; c++) begin
            int t;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sim_time  = sim_time + 10'($urandom_range(0, 2));
            t = int'(sim_time) + int'($urandom_range(0, 8)) - 4;
            in_timestamp = 10'(t & 1023);
            in_data   = 16'($urandom);
            tick();
            n_cmp++;
            if (out_valid !== m_pres || in_ready !== (q_ts.size() < DEP) ||
                occupancy !== 3'(q_ts.size()) || late_count !== 8'(m_lc)) begin
                n_bad++;
                $display("FAIL rand_ctrl c=%0d: valid=%b ready=%b occ=%0d lc=%0d, want %0d %0d %0d %0d",
                         c, out_valid, in_ready, occupancy, late_count,
                         m_pres, q_ts.size() < DEP, q_ts.size(), m_lc);
            end
            if (m_pres) begin
                n_cmp++;
                if (out_data !== 16'(q_data[0]) || out_timestamp !== 10'(q_ts[0])) begin
                    n_bad++;
                    $display("FAIL rand_head c=%0d: data=%h ts=%0d, want %h %0d",
                             c, out_data, out_timestamp, 16'(q_data[0]), q_ts[0]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_due_delay();
        test_wrap();
        test_full();
        test_backpressure();
        test_order();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
